// File: rtl/tl_log_pkg.sv
// Shared TileLink log-collector definitions: channel codes, data-bearing opcodes,
// the has_data decode and the staged-header layout.
package tl_log_pkg;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
  localparam int CH_E = 4;

  localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] OP_PROBE_ACK_DATA   = 3'd5;
  localparam logic [2:0] OP_RELEASE_DATA     = 3'd7;
  localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;
  localparam logic [2:0] OP_GRANT_DATA       = 3'd5;

  localparam int DEFAULT_BEATS = 4;
  localparam int NUM_SLOTS     = 4;

  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [7:0]  source;
    logic [7:0]  sink;
    logic [63:0] address;
    logic [63:0] user;
    logic [63:0] echo;
    logic [63:0] stamp;
  } hdr_t;

  // A and D/C data opcodes are the low / odd codes; B and E never carry data.
  function automatic logic has_data(input int channel, input logic [2:0] opcode);
    case (channel)
      CH_A:       return opcode <= OP_PUT_PARTIAL_DATA;
      CH_C, CH_D: return opcode[0];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tl_log_if.sv
// Snooped TileLink channel: handshake plus header and beat payload.
// The collector only ever listens (slave modport is input-only).
interface tl_log_if;
  logic        tl_valid;
  logic        tl_ready;
  logic [2:0]  tl_opcode;
  logic [2:0]  tl_param;
  logic [7:0]  tl_source;
  logic [7:0]  tl_sink;
  logic [63:0] tl_address;
  logic [63:0] tl_data;
  logic [63:0] tl_user;
  logic [63:0] tl_echo;

  modport master (
    output tl_valid, tl_ready, tl_opcode, tl_param, tl_source, tl_sink,
           tl_address, tl_data, tl_user, tl_echo
  );

  modport slave (
    input  tl_valid, tl_ready, tl_opcode, tl_param, tl_source, tl_sink,
           tl_address, tl_data, tl_user, tl_echo
  );
endinterface

// File: rtl/tl_log_stamp_counter.sv
// Free-running 64-bit cycle counter used as the record timestamp; wraps to 0.
// Value updates every cycle, no backpressure.
module tl_log_stamp_counter (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/tl_log_collector.sv
// Passive TileLink snoop: builds one log record per message, en pulses 1 cycle after
// the last (or only) beat; never backpressures the bus.
module tl_log_collector
  import tl_log_pkg::*;
#(
  parameter int CHANNEL = CH_A,
  parameter int BEATS   = DEFAULT_BEATS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        log_enable,
  tl_log_if.slave     tl,
  output logic        en,
  output logic [63:0] data_echo,
  output logic [63:0] data_user,
  output logic [63:0] data_data_0,
  output logic [63:0] data_data_1,
  output logic [63:0] data_data_2,
  output logic [63:0] data_data_3,
  output logic [63:0] data_address,
  output logic [7:0]  data_sink,
  output logic [7:0]  data_source,
  output logic [7:0]  data_param,
  output logic [7:0]  data_opcode,
  output logic [7:0]  data_channel,
  output logic [63:0] stamp
);

  localparam logic [2:0] LAST = 3'(BEATS - 1);

  state_t      state;
  logic [2:0]  beat_cnt;
  logic [2:0]  skip_cnt;
  hdr_t        hdr;
  hdr_t        cur_hdr;
  hdr_t        pub_hdr;
  logic [63:0] slot     [NUM_SLOTS];
  logic [63:0] pub_data [NUM_SLOTS];
  logic [63:0] cycle_cnt;
  logic        fire;
  logic        hd;
  logic        first_ok;
  logic        publish;

  tl_log_stamp_counter u_stamp (
    .clock (clock),
    .reset (reset),
    .count (cycle_cnt)
  );

  assign fire     = tl.tl_valid & tl.tl_ready;
  assign hd       = has_data(CHANNEL, tl.tl_opcode);
  assign first_ok = (state == ST_IDLE) && (skip_cnt == 3'd0) && log_enable;
  assign publish  = fire && ((first_ok && !hd) || (state == ST_COLLECT && beat_cnt == LAST));

  assign cur_hdr = '{opcode: tl.tl_opcode, param: tl.tl_param, source: tl.tl_source,
                     sink: tl.tl_sink, address: tl.tl_address, user: tl.tl_user,
                     echo: tl.tl_echo, stamp: cycle_cnt};
  assign pub_hdr = (state == ST_COLLECT) ? hdr : cur_hdr;

  // Single-beat records carry no payload; a finishing burst takes its last beat live.
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      pub_data[k] = '0;
      if (state == ST_COLLECT) begin
        if (k < BEATS - 1) begin
          pub_data[k] = slot[k];
        end else if (k == BEATS - 1) begin
          pub_data[k] = tl.tl_data;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      skip_cnt     <= '0;
      hdr          <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) slot[k] <= '0;
      en           <= 1'b0;
      data_echo    <= '0;
      data_user    <= '0;
      data_data_0  <= '0;
      data_data_1  <= '0;
      data_data_2  <= '0;
      data_data_3  <= '0;
      data_address <= '0;
      data_sink    <= '0;
      data_source  <= '0;
      data_param   <= '0;
      data_opcode  <= '0;
      data_channel <= '0;
      stamp        <= '0;
    end else begin
      en <= publish;
      if (fire) begin
        case (state)
          ST_IDLE: begin
            if (skip_cnt != 3'd0) begin
              skip_cnt <= skip_cnt - 3'd1;
            end else if (!log_enable) begin
              if (hd) skip_cnt <= LAST;
            end else if (hd) begin
              hdr      <= cur_hdr;
              slot[0]  <= tl.tl_data;
              beat_cnt <= 3'd1;
              state    <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            slot[beat_cnt[1:0]] <= tl.tl_data;
            if (beat_cnt == LAST) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      // Output registers move only on publish, so a new first beat cannot disturb them.
      if (publish) begin
        data_opcode  <= {5'b0, pub_hdr.opcode};
        data_param   <= {5'b0, pub_hdr.param};
        data_source  <= pub_hdr.source;
        data_sink    <= pub_hdr.sink;
        data_address <= pub_hdr.address;
        data_user    <= pub_hdr.user;
        data_echo    <= pub_hdr.echo;
        stamp        <= pub_hdr.stamp;
        data_channel <= 8'(CHANNEL);
        data_data_0  <= pub_data[0];
        data_data_1  <= pub_data[1];
        data_data_2  <= pub_data[2];
        data_data_3  <= pub_data[3];
      end
    end
  end

endmodule

// File: tb/tb_tl_log_collector.sv
// Scoreboard bench: three collectors (channels A, C, D) snoop one shared bus;
// per-DUT log_enable selects which one is expected to record each message.
module tb_tl_log_collector;
  import tl_log_pkg::*;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  param;
    logic [7:0]  source;
    logic [7:0]  sink;
    logic [63:0] address;
    logic [63:0] user;
    logic [63:0] echo;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] d3;
    logic [63:0] stamp;
    logic [63:0] due;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  le;
  logic [63:0] tb_cyc;
  int          n_run  = 0;
  int          n_fail = 0;
  rec_t        exp_q [3][$];
  int          chs   [3] = '{0, 2, 3};

  logic        o_en      [3];
  logic [63:0] o_echo    [3];
  logic [63:0] o_user    [3];
  logic [63:0] o_d0      [3];
  logic [63:0] o_d1      [3];
  logic [63:0] o_d2      [3];
  logic [63:0] o_d3      [3];
  logic [63:0] o_addr    [3];
  logic [7:0]  o_sink    [3];
  logic [7:0]  o_source  [3];
  logic [7:0]  o_param   [3];
  logic [7:0]  o_opcode  [3];
  logic [7:0]  o_channel [3];
  logic [63:0] o_stamp   [3];

  always #5 clock = ~clock;

  tl_log_if tl ();

  tl_log_collector #(.CHANNEL(0), .BEATS(4)) dut0 (
    .clock(clock), .reset(reset), .log_enable(le[0]), .tl(tl), .en(o_en[0]),
    .data_echo(o_echo[0]), .data_user(o_user[0]), .data_data_0(o_d0[0]), .data_data_1(o_d1[0]),
    .data_data_2(o_d2[0]), .data_data_3(o_d3[0]), .data_address(o_addr[0]), .data_sink(o_sink[0]),
    .data_source(o_source[0]), .data_param(o_param[0]), .data_opcode(o_opcode[0]),
    .data_channel(o_channel[0]), .stamp(o_stamp[0])
  );

  tl_log_collector #(.CHANNEL(2), .BEATS(4)) dut2 (
    .clock(clock), .reset(reset), .log_enable(le[1]), .tl(tl), .en(o_en[1]),
    .data_echo(o_echo[1]), .data_user(o_user[1]), .data_data_0(o_d0[1]), .data_data_1(o_d1[1]),
    .data_data_2(o_d2[1]), .data_data_3(o_d3[1]), .data_address(o_addr[1]), .data_sink(o_sink[1]),
    .data_source(o_source[1]), .data_param(o_param[1]), .data_opcode(o_opcode[1]),
    .data_channel(o_channel[1]), .stamp(o_stamp[1])
  );

  tl_log_collector #(.CHANNEL(3), .BEATS(4)) dut3 (
    .clock(clock), .reset(reset), .log_enable(le[2]), .tl(tl), .en(o_en[2]),
    .data_echo(o_echo[2]), .data_user(o_user[2]), .data_data_0(o_d0[2]), .data_data_1(o_d1[2]),
    .data_data_2(o_d2[2]), .data_data_3(o_d3[2]), .data_address(o_addr[2]), .data_sink(o_sink[2]),
    .data_source(o_source[2]), .data_param(o_param[2]), .data_opcode(o_opcode[2]),
    .data_channel(o_channel[2]), .stamp(o_stamp[2])
  );

  always @(posedge clock) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Header fields are derived from source/address so expectations stay compact.
  function automatic rec_t mk(input logic [2:0] op, input logic [7:0] src, input logic [63:0] addr,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                              input logic [63:0] d, input logic [63:0] st, input logic [63:0] due);
    rec_t r;
    r.opcode  = {5'b0, op};
    r.param   = {5'b0, src[2:0]};
    r.source  = src;
    r.sink    = src + 8'd1;
    r.address = addr;
    r.user    = ~addr;
    r.echo    = {src, src, 48'h0};
    r.d0 = a; r.d1 = b; r.d2 = c; r.d3 = d;
    r.stamp   = st;
    r.due     = due;
    return r;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] src, input logic [63:0] addr,
                       input logic [63:0] dat, input logic [2:0] l);
    tl.tl_valid   = 1'b1;
    tl.tl_ready   = 1'b1;
    tl.tl_opcode  = op;
    tl.tl_param   = src[2:0];
    tl.tl_source  = src;
    tl.tl_sink    = src + 8'd1;
    tl.tl_address = addr;
    tl.tl_data    = dat;
    tl.tl_user    = ~addr;
    tl.tl_echo    = {src, src, 48'h0};
    le            = l;
    @(negedge clock);
    tl.tl_valid   = 1'b0;
    le            = 3'b000;
  endtask

  task automatic wait_until(input logic [63:0] c);
    int n = 0;
    while (tb_cyc != c && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("wait_cycle", tb_cyc, c);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    rec_t e;
    for (int k = 0; k < 3; k++) begin
      if (o_en[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_en", k), 64'd1, 64'd0);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("dut%0d_en_cycle", k), tb_cyc, e.due);
          chk($sformatf("dut%0d_opcode", k), 64'(o_opcode[k]), 64'(e.opcode));
          chk($sformatf("dut%0d_param", k), 64'(o_param[k]), 64'(e.param));
          chk($sformatf("dut%0d_source", k), 64'(o_source[k]), 64'(e.source));
          chk($sformatf("dut%0d_sink", k), 64'(o_sink[k]), 64'(e.sink));
          chk($sformatf("dut%0d_address", k), o_addr[k], e.address);
          chk($sformatf("dut%0d_user", k), o_user[k], e.user);
          chk($sformatf("dut%0d_echo", k), o_echo[k], e.echo);
          chk($sformatf("dut%0d_data0", k), o_d0[k], e.d0);
          chk($sformatf("dut%0d_data1", k), o_d1[k], e.d1);
          chk($sformatf("dut%0d_data2", k), o_d2[k], e.d2);
          chk($sformatf("dut%0d_data3", k), o_d3[k], e.d3);
          chk($sformatf("dut%0d_stamp", k), o_stamp[k], e.stamp);
          chk($sformatf("dut%0d_channel", k), 64'(o_channel[k]), 64'(chs[k]));
        end
      end
    end
  end

  initial begin
    logic [63:0] s;
    logic [2:0]  d_ops [4] = '{3'd0, 3'd6, 3'd4, 3'd2};

    tl.tl_valid = 1'b0; tl.tl_ready = 1'b0; tl.tl_opcode = '0; tl.tl_param = '0;
    tl.tl_source = '0; tl.tl_sink = '0; tl.tl_address = '0; tl.tl_data = '0;
    tl.tl_user = '0; tl.tl_echo = '0; le = 3'b000;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_en%0d", k), 64'(o_en[k]), 64'd0);
      chk($sformatf("rst_stamp%0d", k), o_stamp[k], 64'd0);
      chk($sformatf("rst_opcode%0d", k), 64'(o_opcode[k]), 64'd0);
      chk($sformatf("rst_channel%0d", k), 64'(o_channel[k]), 64'd0);
      chk($sformatf("rst_addr%0d", k), o_addr[k], 64'd0);
    end

    // Channel A Get at stamp 10: no payload, record one cycle later.
    wait_until(64'd10);
    exp_q[0].push_back(mk(3'd4, 8'h12, 64'h8000_1000, 0, 0, 0, 0, 64'd10, 64'd11));
    drive(3'd4, 8'h12, 64'h8000_1000, 64'hDEAD_BEEF, 3'b001);
    repeat (2) @(negedge clock);

    // Channel D GrantData with a stalled cycle (valid without ready) mid-burst.
    s = tb_cyc;
    drive(OP_GRANT_DATA, 8'h31, 64'h1000, 64'h11, 3'b100);
    drive(OP_GRANT_DATA, 8'h77, 64'h2000, 64'h22, 3'b100);
    tl.tl_valid = 1'b1; tl.tl_ready = 1'b0;
    @(negedge clock);
    tl.tl_valid = 1'b0; tl.tl_ready = 1'b1;
    drive(OP_GRANT_DATA, 8'h78, 64'h2008, 64'h33, 3'b100);
    exp_q[2].push_back(mk(OP_GRANT_DATA, 8'h31, 64'h1000, 64'h11, 64'h22, 64'h33, 64'h44, s, tb_cyc + 1));
    drive(OP_GRANT_DATA, 8'h79, 64'h2010, 64'h44, 3'b100);
    repeat (3) @(negedge clock);

    // Channel C ReleaseData with log_enable low: its tail beats must be skipped.
    drive(OP_RELEASE_DATA, 8'h40, 64'h3000, 64'hA1, 3'b000);
    for (int i = 1; i < 4; i++) drive(3'd4, 8'h41, 64'h3000 + 64'(i * 8), 64'hA1 + 64'(i), 3'b010);
    exp_q[1].push_back(mk(3'd4, 8'h55, 64'h4000, 0, 0, 0, 0, tb_cyc, tb_cyc + 1));
    drive(3'd4, 8'h55, 64'h4000, 64'hBB, 3'b010);
    repeat (3) @(negedge clock);

    // Reset in the middle of a channel A PutFullData, then a fresh Get.
    drive(OP_PUT_FULL_DATA, 8'h60, 64'h5000, 64'h1, 3'b001);
    drive(OP_PUT_FULL_DATA, 8'h60, 64'h5000, 64'h2, 3'b001);
    pulse_reset();
    chk("rst2_opcode0", 64'(o_opcode[0]), 64'd0);
    chk("rst2_stamp0", o_stamp[0], 64'd0);
    wait_until(64'd3);
    exp_q[0].push_back(mk(3'd4, 8'h66, 64'h8000_2000, 0, 0, 0, 0, 64'd3, 64'd4));
    drive(3'd4, 8'h66, 64'h8000_2000, 64'h5, 3'b001);
    repeat (3) @(negedge clock);

    // Back-to-back single-beat D messages, then two GrantData bursts each starting under en.
    for (int i = 0; i < 4; i++) begin
      exp_q[2].push_back(mk(d_ops[i], 8'h70 + 8'(i), 64'h6000 + 64'(i * 8), 0, 0, 0, 0, tb_cyc, tb_cyc + 1));
      drive(d_ops[i], 8'h70 + 8'(i), 64'h6000 + 64'(i * 8), 64'hF0 + 64'(i), 3'b100);
    end
    for (int m = 0; m < 2; m++) begin
      s = tb_cyc;
      for (int b = 0; b < 4; b++) begin
        if (b == 3)
          exp_q[2].push_back(mk(OP_GRANT_DATA, 8'h80 + 8'(m), 64'h7000 + 64'(m * 64),
                                64'hC0 + 64'(m * 16), 64'hC1 + 64'(m * 16),
                                64'hC2 + 64'(m * 16), 64'hC3 + 64'(m * 16), s, tb_cyc + 1));
        drive(OP_GRANT_DATA, (b == 0) ? 8'h80 + 8'(m) : 8'hEE, (b == 0) ? 64'h7000 + 64'(m * 64) : 64'h9999,
              64'hC0 + 64'(m * 16) + 64'(b), 3'b100);
      end
    end
    repeat (3) @(negedge clock);

    // Counter wrap on the channel A collector.
    pulse_reset();
    force dut0.u_stamp.count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut0.u_stamp.count;
    exp_q[0].push_back(mk(3'd4, 8'h90, 64'hA000, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, tb_cyc + 1));
    drive(3'd4, 8'h90, 64'hA000, 64'h0, 3'b001);
    exp_q[0].push_back(mk(3'd4, 8'h91, 64'hA008, 0, 0, 0, 0, 64'd0, tb_cyc + 1));
    drive(3'd4, 8'h91, 64'hA008, 64'h0, 3'b001);
    repeat (4) @(negedge clock);

    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d_missing_records", k), 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
